// File: rtl/epp_cmd_framer_if.sv
// EPP command framer bus bundle.
// Groups the host byte port (busBramIn, dataStb) with the framer results
// (wordOut, chSel, loadStb, stmBusy, cmdErr, toErr).
//   master : host side, drives byte and strobe, observes results
//   slave  : framer side, observes byte and strobe, drives results
interface epp_cmd_framer_if #(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 2,
  parameter int NUM_CH     = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0]            busBramIn;
  logic                         dataStb;
  logic [DATA_W*WORD_BYTES-1:0] wordOut;
  logic [CH_W-1:0]              chSel;
  logic [NUM_CH-1:0]            loadStb;
  logic                         stmBusy;
  logic                         cmdErr;
  logic                         toErr;

  modport master (
    output busBramIn, dataStb,
    input  wordOut, chSel, loadStb, stmBusy, cmdErr, toErr
  );

  modport slave (
    input  busBramIn, dataStb,
    output wordOut, chSel, loadStb, stmBusy, cmdErr, toErr
  );
endinterface

// File: rtl/epp_cmd_framer.sv
// Strobe-driven command framer between the EPP byte port and the per-channel
// config loaders. Packets are CMD, KEY, then WORD_BYTES data bytes (MSB first).
// A completed packet updates wordOut/chSel and fires a one-hot, one-cycle
// loadStb for channel CMD-1. Bad CMD/KEY pulses cmdErr; a stalled packet
// pulses toErr after TIMEOUT cycles without an accepted byte.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : epp_cmd_framer_if slave modport (byte/strobe in, results out)
module epp_cmd_framer #(
  parameter int               DATA_W      = 8,
  parameter int               WORD_BYTES  = 2,
  parameter int               NUM_CH      = 4,
  parameter logic [DATA_W-1:0] KEY        = 8'h55,
  parameter int               SYNC_STAGES = 2,
  parameter int               TIMEOUT     = 1000
) (
  input  logic clk,
  input  logic rst,
  epp_cmd_framer_if.slave bus
);

  localparam int W    = DATA_W * WORD_BYTES;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(WORD_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] NCH_B     = DATA_W'(NUM_CH);

  typedef enum logic [1:0] {IDLE, KEY_S, DATA_S, COMMIT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] stb_sync;
  logic                   stb_prev;
  logic [CH_W-1:0]        ch;
  logic [W-1:0]           shift;
  logic [W-1:0]           shift_next;
  logic [BC_W-1:0]        bcnt;
  logic [TO_W-1:0]        tcnt;
  logic                   accept;
  logic                   cmd_ok;

  // Falling edge of the synchronised strobe; the host keeps busBramIn stable
  // while the strobe is low, so it can be sampled directly in this cycle.
  assign accept = stb_prev & ~stb_sync[SYNC_STAGES-1];
  assign cmd_ok = (bus.busBramIn != '0) && (bus.busBramIn <= NCH_B);

  if (WORD_BYTES > 1) begin : g_multi
    assign shift_next = {shift[W-DATA_W-1:0], bus.busBramIn};
  end else begin : g_single
    assign shift_next = bus.busBramIn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_sync    <= '1;
      stb_prev    <= 1'b1;
      state       <= IDLE;
      ch          <= '0;
      shift       <= '0;
      bcnt        <= '0;
      tcnt        <= '0;
      bus.wordOut <= '0;
      bus.chSel   <= '0;
      bus.loadStb <= '0;
      bus.stmBusy <= 1'b0;
      bus.cmdErr  <= 1'b0;
      bus.toErr   <= 1'b0;
    end else begin
      // strobe synchroniser and edge-detect flop
      stb_sync    <= {stb_sync[SYNC_STAGES-2:0], bus.dataStb};
      stb_prev    <= stb_sync[SYNC_STAGES-1];
      bus.loadStb <= '0;
      bus.cmdErr  <= 1'b0;
      bus.toErr   <= 1'b0;
      case (state)
        // COMMIT lasts one cycle and treats any accept like IDLE does,
        // so back-to-back packets lose no byte.
        IDLE, COMMIT: begin
          tcnt <= '0;
          if (accept && cmd_ok) begin
            ch          <= CH_W'(bus.busBramIn - DATA_W'(1));
            state       <= KEY_S;
            bus.stmBusy <= 1'b1;
          end else begin
            bus.cmdErr  <= accept;
            state       <= IDLE;
            bus.stmBusy <= 1'b0;
          end
        end
        KEY_S, DATA_S: begin
          if (accept) begin
            // an accept in the expiry cycle wins over the timeout
            tcnt <= '0;
            if (state == KEY_S) begin
              if (bus.busBramIn == KEY) begin
                state <= DATA_S;
                bcnt  <= '0;
                shift <= '0;
              end else begin
                bus.cmdErr  <= 1'b1;
                state       <= IDLE;
                bus.stmBusy <= 1'b0;
              end
            end else begin
              shift <= shift_next;
              bcnt  <= bcnt + 1'b1;
              if (bcnt == LAST_BYTE) begin
                state       <= COMMIT;
                bus.wordOut <= shift_next;
                bus.chSel   <= ch;
                bus.loadStb <= NUM_CH'(1) << ch;
              end
            end
          end else if (tcnt == TO_LAST) begin
            bus.toErr   <= 1'b1;
            state       <= IDLE;
            bus.stmBusy <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/epp_cmd_framer.md
Name: epp_cmd_framer

Overview:
- Strobe-driven command framer between the EPP byte port (busBramIn/dataStb) and the per-channel config loaders (DAC, digital pots, mux, ADC setup).
- Assembles packets of the form CMD, KEY, then WORD_BYTES data bytes, sent MSB first.
- Delivers a full-width word plus a one-hot, one-cycle load strobe for the addressed channel.
- Generalises the fixed 3-byte command/0x55/data framing with parametrised word width, channel count, key value, sync depth and an inter-byte timeout.

Parameters:
- DATA_W, 8, width of the byte bus.
- WORD_BYTES, 2, data bytes per packet; wordOut width = DATA_W*WORD_BYTES.
- NUM_CH, 4, number of load channels. Valid CMD values are 1..NUM_CH; channel index = CMD-1.
- KEY, 8'h55, required second byte of every packet.
- SYNC_STAGES, 2, flops in the dataStb synchroniser (minimum 2).
- TIMEOUT, 1000, clk cycles allowed between accepted bytes inside a packet.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- busBramIn  in  DATA_W  host byte; held stable while dataStb is low.
- dataStb  in  1  host data strobe, active-low, asynchronous to clk.
- wordOut  out  DATA_W*WORD_BYTES  last committed word.
- chSel  out  clog2(NUM_CH) (min 1)  channel index of the last commit.
- loadStb  out  NUM_CH  one-hot load pulse, 1 cycle.
- stmBusy  out  1  high while a packet is in progress.
- cmdErr  out  1  1-cycle pulse on an invalid CMD or KEY mismatch.
- toErr  out  1  1-cycle pulse on an inter-byte timeout.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; wordOut=0; chSel=0; loadStb=0; stmBusy=0; cmdErr=0; toErr=0; shift register=0; timeout counter=0; synchroniser flops=1 (strobe idle high).
- Byte accept:
  - dataStb passes through SYNC_STAGES flops, then one extra flop for edge detection.
  - A byte is accepted on the cycle the synchronised strobe shows a 1->0 transition. busBramIn is sampled in that same cycle.
  - Pin-to-accept latency = SYNC_STAGES+1 cycles.
  - A strobe held low produces exactly one accept. Glitches shorter than 1 clk may be missed; this is a host requirement, not a block fault.
- States:
  - IDLE: on accept, if 1<=byte<=NUM_CH, latch ch=byte-1 and go to KEY_S. Otherwise pulse cmdErr and stay in IDLE.
  - KEY_S: on accept, if byte==KEY, clear the byte counter and go to DATA_S. Otherwise pulse cmdErr and go to IDLE; the mismatched byte is NOT reinterpreted as a CMD.
  - DATA_S: on accept, shift[W-1:0] = {shift[W-DATA_W-1:0], byte} and increment the byte counter. On the WORD_BYTES-th byte, go to COMMIT.
  - COMMIT (exactly 1 cycle): wordOut<=shift; chSel<=ch; loadStb<=(1<<ch) for this cycle only; return to IDLE. An accept arriving in this cycle is processed as a CMD byte, with the same rules as IDLE.
- stmBusy is 1 in KEY_S, DATA_S and COMMIT, and 0 in IDLE. It rises the cycle after the CMD accept.
- Packet latency: loadStb is high in the cycle after the last data byte is accepted.
- wordOut and chSel hold their values between commits. Failed or aborted packets never alter them.
- Timeout:
  - The counter clears on every accept and increments every cycle in KEY_S or DATA_S.
  - When it reaches TIMEOUT-1 with no accept in that cycle: pulse toErr, return to IDLE, discard the partial word.
  - If an accept and the expiry happen in the same cycle, the accept wins.
  - The counter is held at 0 in IDLE.
- cmdErr and toErr never assert in the same cycle. loadStb and either error never assert in the same cycle.
- Reset mid-packet aborts the packet with no loadStb and no error pulse. Outputs take their reset values on the next edge.
- The block has no backpressure: the host paces bytes, with at least SYNC_STAGES+2 cycles of high and of low per strobe.

Test Plan:
- Defaults. Send 03,55,12,34 with 30 ns low strobes and 300 ns gaps -> one cycle with loadStb=4'b0100, chSel=2, wordOut=16'h1234. stmBusy high from the first accept+1 to the commit cycle.
- Send 02,AA,01 -> cmdErr pulses once on AA. Packet 01 then starts (stmBusy=1) and times out after 1000 idle cycles -> toErr pulses once. wordOut is unchanged.
- Send CMD 00, then CMD 05 -> two cmdErr pulses, state stays IDLE, stmBusy stays 0, no loadStb.
- Send 04,55,EE and then stop -> toErr exactly 1000 cycles after the EE accept, no loadStb. Then send 01,55,AB,CD -> loadStb=4'b0001, wordOut=16'hABCD.
- Assert rst for 1 cycle after 03,55,12 -> stmBusy=0 and all outputs 0 next cycle. Then send 03,55,56,78 -> loadStb=4'b0100, wordOut=16'h5678, with no stale 12 byte.
- Re-run with NUM_CH=8, WORD_BYTES=3, KEY=8'hA5. Send 08,A5,01,02,03 -> loadStb=8'h80, wordOut=24'h010203. Send 08,55 -> cmdErr.
